// File: rtl/line_overlay.sv
// Raster line-overlay stage: tests each pixel against up to NUM_LINES Hough lines
// and recolours, masks or passes it, between two FWFT FIFOs with a 2-stage pipe.
module line_overlay #(
  parameter int                     WIDTH           = 720,
  parameter int                     HEIGHT          = 540,
  parameter int                     NUM_LINES       = 4,
  parameter int                     PIXEL_WIDTH     = 24,
  parameter int                     COEF_FRAC       = 8,
  parameter int                     RADIUS_WIDTH    = 16,
  parameter int                     TOLERANCE       = 1,
  parameter logic [PIXEL_WIDTH-1:0] HIGHLIGHT_COLOR = 24'hFF0000
) (
  input  logic                                                clk,
  input  logic                                                rst_n,
  input  logic                                                in_empty,
  output logic                                                in_rd_en,
  input  logic [PIXEL_WIDTH-1:0]                              in_dout,
  input  logic                                                out_full,
  output logic                                                out_wr_en,
  output logic [PIXEL_WIDTH-1:0]                              out_din,
  input  logic                                                cfg_wr,
  input  logic [((NUM_LINES > 1) ? $clog2(NUM_LINES) : 1)-1:0] cfg_idx,
  input  logic                                                cfg_en,
  input  logic signed [COEF_FRAC+1:0]                         cfg_cos,
  input  logic signed [COEF_FRAC+1:0]                         cfg_sin,
  input  logic signed [RADIUS_WIDTH-1:0]                      cfg_rho,
  input  logic [1:0]                                          cfg_mode,
  output logic                                                frame_done,
  output logic                                                busy
);

  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int CW = COEF_FRAC + 2;
  localparam int PW = ((XW > YW) ? XW : YW) + CW + 3;
  localparam int RW = RADIUS_WIDTH + COEF_FRAC + 2;
  localparam int SW = (PW > RW) ? PW : RW;
  localparam logic signed [SW-1:0] TOL = SW'(TOLERANCE) <<< COEF_FRAC;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_OVERLAY = 2'd1,
    MODE_MASK    = 2'd2,
    MODE_LINES   = 2'd3
  } mode_t;

  logic [XW-1:0] x, s1_x;
  logic [YW-1:0] y, s1_y;

  logic                           sh_en  [NUM_LINES];
  logic signed [CW-1:0]           sh_cos [NUM_LINES];
  logic signed [CW-1:0]           sh_sin [NUM_LINES];
  logic signed [RADIUS_WIDTH-1:0] sh_rho [NUM_LINES];
  logic                           act_en  [NUM_LINES];
  logic signed [CW-1:0]           act_cos [NUM_LINES];
  logic signed [CW-1:0]           act_sin [NUM_LINES];
  logic signed [RADIUS_WIDTH-1:0] act_rho [NUM_LINES];
  mode_t                          sh_mode, act_mode;

  logic                   s1_valid, s2_valid, s2_last, busy_r;
  logic [PIXEL_WIDTH-1:0] s1_pix, s2_result, result;
  logic                   advance, first_pix, s1_last, hit_any;

  assign in_rd_en   = !in_empty && !out_full && rst_n;
  assign advance    = !out_full;
  assign first_pix  = (x == '0) && (y == '0);
  assign s1_last    = (s1_x == XW'(WIDTH - 1)) && (s1_y == YW'(HEIGHT - 1));
  assign out_wr_en  = s2_valid && !out_full;
  assign out_din    = s2_result;
  assign frame_done = out_wr_en && s2_last;
  assign busy       = busy_r || s1_valid || s2_valid;

  // Full-width signed arithmetic so no line parameter can overflow the distance test.
  always_comb begin : hit_calc
    logic signed [SW-1:0] xs, ys, d, diff, adiff;
    xs      = SW'(signed'({1'b0, s1_x}));
    ys      = SW'(signed'({1'b0, s1_y}));
    d       = '0;
    diff    = '0;
    adiff   = '0;
    hit_any = 1'b0;
    for (int unsigned i = 0; i < NUM_LINES; i++) begin
      d     = xs * SW'(act_cos[i]) + ys * SW'(act_sin[i]);
      diff  = d - (SW'(act_rho[i]) <<< COEF_FRAC);
      adiff = diff[SW-1] ? -diff : diff;
      if (act_en[i] && (adiff <= TOL)) hit_any = 1'b1;
    end
  end

  always_comb begin
    result = s1_pix;
    case (act_mode)
      MODE_PASS:    result = s1_pix;
      MODE_OVERLAY: result = hit_any ? HIGHLIGHT_COLOR : s1_pix;
      MODE_MASK:    result = hit_any ? s1_pix : '0;
      MODE_LINES:   result = hit_any ? HIGHLIGHT_COLOR : '0;
      default:      result = s1_pix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x         <= '0;
      y         <= '0;
      sh_en     <= '{default: '0};
      sh_cos    <= '{default: '0};
      sh_sin    <= '{default: '0};
      sh_rho    <= '{default: '0};
      act_en    <= '{default: '0};
      act_cos   <= '{default: '0};
      act_sin   <= '{default: '0};
      act_rho   <= '{default: '0};
      sh_mode   <= MODE_PASS;
      act_mode  <= MODE_PASS;
      s1_valid  <= 1'b0;
      s1_pix    <= '0;
      s1_x      <= '0;
      s1_y      <= '0;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_last   <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_mode <= mode_t'(cfg_mode);
        if (int'(cfg_idx) < NUM_LINES) begin
          sh_en[cfg_idx]  <= cfg_en;
          sh_cos[cfg_idx] <= cfg_cos;
          sh_sin[cfg_idx] <= cfg_sin;
          sh_rho[cfg_idx] <= cfg_rho;
        end
      end
      if (out_wr_en && s2_last) busy_r <= 1'b0;
      if (in_rd_en) begin
        if (x == XW'(WIDTH - 1)) begin
          x <= '0;
          y <= (y == YW'(HEIGHT - 1)) ? '0 : y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
        // Bank swap reads the pre-write shadow, so a same-cycle cfg_wr waits a frame.
        if (first_pix) begin
          act_en   <= sh_en;
          act_cos  <= sh_cos;
          act_sin  <= sh_sin;
          act_rho  <= sh_rho;
          act_mode <= sh_mode;
          busy_r   <= 1'b1;
        end
      end
      if (advance) begin
        s1_valid <= in_rd_en;
        if (in_rd_en) begin
          s1_pix <= in_dout;
          s1_x   <= x;
          s1_y   <= y;
        end
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_result <= result;
          s2_last   <= s1_last;
        end
      end
    end
  end

endmodule

// File: doc/line_overlay.md
# line_overlay

Parametrised successor to the single-line highlight stage in the Canny/Hough pipeline. It consumes a raster RGB stream from a first-word-fall-through FIFO and compares every pixel against up to NUM_LINES Hough lines (cos, sin, rho). It recolours, masks or passes the pixel according to a per-frame mode, then writes the result to a downstream FIFO. Line parameters and mode are written at any time into shadow registers and take effect atomically at the next frame start.

## Interface
- WIDTH, 720, pixels per line
- HEIGHT, 540, lines per frame
- NUM_LINES, 4, line comparators (1..8)
- PIXEL_WIDTH, 24, pixel bits (RGB888)
- COEF_FRAC, 8, fractional bits of signed cos/sin coefficients
- RADIUS_WIDTH, 16, signed rho width
- TOLERANCE, 1, hit half-width in whole pixels
- HIGHLIGHT_COLOR, 24'hFF0000, overlay colour
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-low
- in_empty  in  1  upstream FIFO empty
- in_rd_en  out  1  upstream pop; in_dout valid in same cycle
- in_dout  in  PIXEL_WIDTH  input pixel
- out_full  in  1  downstream FIFO full
- out_wr_en  out  1  downstream push
- out_din  out  PIXEL_WIDTH  output pixel
- cfg_wr  in  1  shadow write strobe
- cfg_idx  in  $clog2(NUM_LINES)  target line
- cfg_en  in  1  line enable
- cfg_cos, cfg_sin  in  COEF_FRAC+2 each  signed Q1.COEF_FRAC
- cfg_rho  in  RADIUS_WIDTH  signed rho in pixels
- cfg_mode  in  2  0 pass, 1 overlay, 2 mask, 3 lines-only
- frame_done  out  1  one-cycle pulse
- busy  out  1  frame in progress or pipeline non-empty

## Operation
- Counters x (0..WIDTH-1), y (0..HEIGHT-1) advance on each in_rd_en. x wraps to 0 and increments y; at (WIDTH-1, HEIGHT-1) both wrap to 0.
- Shadow bank: cfg_wr writes {en, cos, sin, rho} at cfg_idx and the shadow mode. An out-of-range cfg_idx is ignored.
- Active bank is loaded from shadow on the in_rd_en that consumes pixel (0,0). A cfg_wr in the same cycle lands in shadow only and takes effect the following frame.
- Per line: d = x·cos + y·sin, exact signed full width with no truncation. Hit when |d − (rho << COEF_FRAC)| ≤ (TOLERANCE << COEF_FRAC) and en = 1. hit_any is the OR over all lines.
- Mode 0: output equals input.
- Mode 1: hit → HIGHLIGHT_COLOR, else input.
- Mode 2: hit → input, else 0.
- Mode 3: hit → HIGHLIGHT_COLOR, else 0.
- frame_done pulses for one cycle alongside the out_wr_en of pixel (WIDTH-1, HEIGHT-1).

## Timing
- Two register stages. S1 latches {pixel, x, y, valid}. S2 latches {result, last, valid}.
- The pipeline advances only when out_full = 0; the whole pipeline is a global stall.
- in_rd_en = !in_empty && !out_full && reset deasserted (combinational).
- out_wr_en = S2.valid && !out_full (combinational); out_din = S2 result.
- Latency: a pixel popped in cycle t is pushed in cycle t+2 when out_full stays low. Each cycle of out_full adds one cycle. No pixel is lost or duplicated.
- Throughput is one pixel per cycle when the input is non-empty and the output is not full.
- While reset is low, all registers clear asynchronously:
  - x, y, valids → 0
  - active and shadow lines disabled, coefficients 0, mode 0
  - out_din = 0, out_wr_en = 0, frame_done = 0, busy = 0, in_rd_en = 0
- Reset mid-frame discards in-flight pixels; the next pixel after release is (0,0).
- busy is high from the (0,0) pop until the last pixel is pushed.

## Test plan
- Use WIDTH=8, HEIGHT=4, TOLERANCE=0 for all scenarios.
- Mode 0: stream 32 pixels with value 24'h00_00_k, k = 0..31 → identical output in order, frame_done on the 32nd push only, latency 2.
- Mode 1, line 0: cos=256, sin=0, rho=3 → pixels at x=3 (4 of them) output FF0000, all others unchanged.
- Mode 3, two lines: (cos=0, sin=256, rho=2) and (cos=256, sin=0, rho=0) → row y=2 plus column x=0 are FF0000 (11 pixels), other 21 pixels are 0.
- Backpressure: hold out_full high for 5 cycles mid-frame, and toggle in_empty randomly → output sequence bit-identical to the unstalled run, no push while out_full = 1.
- Config timing: change rho 3→5 by cfg_wr during frame 1, including one write in the same cycle as the (0,0) pop of frame 2 → frame 1 uses 3, frame 2 uses the pre-write shadow, frame 3 uses the new value.
- Reset: assert reset after pixel 13 → outputs 0 immediately; after release, the first output is pixel (0,0) with mode 0 behaviour.
